// File: rtl/hc4511_scan_ctrl.sv
// Multiplexed display scanner driving a shared HC4511 decoder/latch.
// Double-buffered digit data; every output is registered from next-state decode.
module hc4511_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int SHOW_CYCLES = 1000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [4*DIGITS-1:0]   i_data,
  input  logic                  i_load,
  input  logic                  i_en,
  input  logic                  i_lz_blank,
  input  logic                  i_lamp_test,
  output logic [3:0]            o_a,
  output logic                  o_le,
  output logic                  o_bi_n,
  output logic                  o_lt_n,
  output logic [DIGITS-1:0]     o_dig_n,
  output logic                  o_frame
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (SHOW_CYCLES > 2) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HOLD, S_SHOW, S_LAMP} state_t;

  state_t              r_state, w_state_nxt;
  logic [IW-1:0]       r_idx, w_idx_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic [4*DIGITS-1:0] r_shadow, r_active, w_active_nxt;
  logic                w_frame_start;
  logic [3:0]          w_code;
  logic                w_upper_zero, w_blank;

  logic [3:0]          r_a, w_a_nxt;
  logic                r_le, w_le_nxt;
  logic                r_bi_n, w_bi_n_nxt;
  logic                r_lt_n, w_lt_n_nxt;
  logic [DIGITS-1:0]   r_dig_n, w_dig_n_nxt;
  logic                r_frame;

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_cnt_nxt     = r_cnt;
    w_frame_start = 1'b0;
    if (!i_en) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
    end else if (i_lamp_test) begin
      w_state_nxt = S_LAMP;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE, S_LAMP: begin
          w_state_nxt   = S_SETUP;
          w_idx_nxt     = '0;
          w_cnt_nxt     = '0;
          w_frame_start = 1'b1;
        end
        S_SETUP: begin
          if (r_cnt == CNT_ONE) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        S_HOLD: begin
          w_state_nxt = S_SHOW;
          w_cnt_nxt   = '0;
        end
        S_SHOW: begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_SETUP;
            w_cnt_nxt   = '0;
            if (r_idx == IDX_LAST) begin
              w_idx_nxt     = '0;
              w_frame_start = 1'b1;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // A LOAD on the frame-start edge bypasses the shadow so it shows in this frame.
  assign w_active_nxt = w_frame_start ? (i_load ? i_data : r_shadow) : r_active;
  assign w_code       = w_active_nxt[{w_idx_nxt, 2'b00} +: 4];

  always_comb begin
    w_upper_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++)
      if (j >= int'(w_idx_nxt) && w_active_nxt[4*j +: 4] != 4'd0) w_upper_zero = 1'b0;
    w_blank = i_lz_blank && (w_idx_nxt != '0) && w_upper_zero;
  end

  always_comb begin
    w_a_nxt     = '0;
    w_le_nxt    = 1'b1;
    w_bi_n_nxt  = 1'b0;
    w_lt_n_nxt  = 1'b1;
    w_dig_n_nxt = '1;
    case (w_state_nxt)
      S_SETUP: begin
        w_a_nxt  = w_code;
        w_le_nxt = 1'b0;
      end
      S_HOLD: w_a_nxt = w_code;
      S_SHOW: begin
        w_a_nxt    = w_code;
        w_bi_n_nxt = !w_blank;
        if (!w_blank) w_dig_n_nxt[w_idx_nxt] = 1'b0;
      end
      S_LAMP: begin
        w_a_nxt     = r_a;
        w_bi_n_nxt  = 1'b1;
        w_lt_n_nxt  = 1'b0;
        w_dig_n_nxt = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_active <= '0;
      r_a      <= '0;
      r_le     <= 1'b1;
      r_bi_n   <= 1'b0;
      r_lt_n   <= 1'b1;
      r_dig_n  <= '1;
      r_frame  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_cnt    <= w_cnt_nxt;
      if (i_load) r_shadow <= i_data;
      r_active <= w_active_nxt;
      r_a      <= w_a_nxt;
      r_le     <= w_le_nxt;
      r_bi_n   <= w_bi_n_nxt;
      r_lt_n   <= w_lt_n_nxt;
      r_dig_n  <= w_dig_n_nxt;
      r_frame  <= w_frame_start;
    end
  end

  assign o_a     = r_a;
  assign o_le    = r_le;
  assign o_bi_n  = r_bi_n;
  assign o_lt_n  = r_lt_n;
  assign o_dig_n = r_dig_n;
  assign o_frame = r_frame;
endmodule

// File: tb/tb_hc4511_scan_ctrl.sv
// Scoreboard bench for hc4511_scan_ctrl: expected digit slots are queued per frame
// and compared as the monitor sees each slot complete.
module tb_hc4511_scan_ctrl;
  localparam int DIGITS = 4;
  localparam int SHOW   = 4;

  logic        clk, rst_n, load, en, lz, lamp;
  logic [15:0] data;
  logic [3:0]  a;
  logic        le, bi_n, lt_n, frame;
  logic [3:0]  dig_n;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] dig;
    int         len;
  } slot_t;
  slot_t q[$];

  hc4511_scan_ctrl #(.DIGITS(DIGITS), .SHOW_CYCLES(SHOW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_load(load), .i_en(en),
    .i_lz_blank(lz), .i_lamp_test(lamp), .o_a(a), .o_le(le), .o_bi_n(bi_n),
    .o_lt_n(lt_n), .o_dig_n(dig_n), .o_frame(frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [15:0] d, input logic lzb);
    slot_t      s;
    logic       upz;
    logic [3:0] one;
    one = 4'b0001;
    for (int i = 0; i < DIGITS; i++) begin
      upz = 1'b1;
      for (int j = i; j < DIGITS; j++) if (d[4*j +: 4] != 4'd0) upz = 1'b0;
      s.a = d[4*i +: 4];
      if (lzb && i != 0 && upz) begin
        s.dig = 4'hF;
        s.len = 0;
      end else begin
        s.dig = ~(one << i);
        s.len = SHOW;
      end
      q.push_back(s);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_A"}, 32'(a), 0);
    chk({p, "_LE"}, 32'(le), 1);
    chk({p, "_BIN"}, 32'(bi_n), 0);
    chk({p, "_LTN"}, 32'(lt_n), 1);
    chk({p, "_DIGN"}, 32'(dig_n), 32'hF);
    chk({p, "_FRAME"}, 32'(frame), 0);
  endtask

  task automatic wait_frame(input string tag, input int maxc);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame && k < maxc);
    if (!frame) chk({tag, "_TMO"}, 0, 1);
  endtask

  task automatic wait_dig(input string tag, input logic [3:0] pat, input int maxc);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (dig_n !== pat && k < maxc);
    if (dig_n !== pat) chk({tag, "_TMO"}, 0, 1);
  endtask

  task automatic drain(input string tag, input int maxc);
    int k;
    k = 0;
    while (q.size() != 0 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_DRAIN"}, q.size(), 0);
  endtask

  // Slot monitor: a slot opens on LE falling and closes when the next one opens.
  initial begin
    logic       prev_le, in_slot;
    logic [3:0] s_a, s_dig;
    int         s_len, s_le0;
    slot_t      e;
    prev_le = 1'b1;
    in_slot = 1'b0;
    s_a = '0; s_dig = '1; s_len = 0; s_le0 = 0;
    forever begin
      @(negedge clk);
      if (le == 1'b0 && prev_le == 1'b1) begin
        if (in_slot) begin
          e = q.pop_front();
          chk("SLOT_A", 32'(s_a), 32'(e.a));
          chk("SLOT_DIG", 32'(s_dig), 32'(e.dig));
          chk("SLOT_LEN", s_len, e.len);
          chk("SLOT_LE0", s_le0, 2);
        end
        in_slot = (q.size() != 0);
        s_a = a; s_dig = 4'hF; s_len = 0; s_le0 = 1;
      end else if (in_slot && le == 1'b0) begin
        s_le0++;
      end else if (in_slot && le && bi_n && lt_n) begin
        s_dig = dig_n;
        s_len++;
      end
      prev_le = le;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog n_err=%0d", n_err);
    $fatal(1);
  end

  initial begin
    int t0;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; lz = 1'b0; lamp = 1'b0; data = '0;
    repeat (3) @(negedge clk);
    chk_reset("RESET");
    rst_n = 1'b1;

    // basic scan, frame period, and setup for double buffering
    data = 16'h1234; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    push_frame(16'h1234, 1'b0);
    push_frame(16'h1234, 1'b0);
    push_frame(16'h1234, 1'b0);
    en = 1'b1;
    @(negedge clk);
    chk("FRAME_FIRST", 32'(frame), 1);
    chk("FIRST_A", 32'(a), 4);
    chk("FIRST_LE", 32'(le), 0);
    t0 = cyc;
    wait_frame("F2", 60);
    chk("FRAME_PERIOD", cyc - t0, DIGITS * (SHOW + 3));
    wait_frame("F3", 60);
    wait_dig("DB", 4'b1101, 40);
    repeat (2) @(negedge clk);
    data = 16'h5678; load = 1'b1;
    push_frame(16'h5678, 1'b0);
    @(negedge clk);
    load = 1'b0;
    drain("DBUF", 300);

    // leading-zero blanking; LOAD on the frame-start edge takes effect at once
    en = 1'b0;
    repeat (3) @(negedge clk);
    data = 16'h0040; load = 1'b1; lz = 1'b1; en = 1'b1;
    push_frame(16'h0040, 1'b1);
    push_frame(16'h0000, 1'b1);
    @(negedge clk);
    chk("LZ_FRAME", 32'(frame), 1);
    data = 16'h0000;
    @(negedge clk);
    load = 1'b0;
    drain("LZ", 300);

    // codes 10..15 pass through
    en = 1'b0; lz = 1'b0;
    repeat (3) @(negedge clk);
    data = 16'hF9AB; load = 1'b1; en = 1'b1;
    push_frame(16'hF9AB, 1'b0);
    @(negedge clk);
    load = 1'b0;
    drain("INV", 300);

    // lamp test during digit 2
    wait_dig("LAMP", 4'b1011, 40);
    lamp = 1'b1;
    @(negedge clk);
    chk("LAMP_LTN", 32'(lt_n), 0);
    chk("LAMP_DIGN", 32'(dig_n), 0);
    chk("LAMP_BIN", 32'(bi_n), 1);
    chk("LAMP_LE", 32'(le), 1);
    repeat (2) @(negedge clk);
    push_frame(16'hF9AB, 1'b0);
    lamp = 1'b0;
    @(negedge clk);
    chk("LREL_FRAME", 32'(frame), 1);
    chk("LREL_LE", 32'(le), 0);
    chk("LREL_LTN", 32'(lt_n), 1);
    chk("LREL_DIGN", 32'(dig_n), 32'hF);
    chk("LREL_A", 32'(a), 32'hB);
    drain("LREL", 300);

    // disable mid-SHOW
    wait_dig("DIS", 4'b1101, 40);
    en = 1'b0;
    @(negedge clk);
    chk_reset("DIS");

    // reset mid-frame with EN held high
    en = 1'b1;
    wait_frame("RF", 40);
    wait_dig("RST", 4'b1011, 40);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("RST");
    push_frame(16'h0000, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("RST_FRAME", 32'(frame), 1);
    chk("RST_A", 32'(a), 0);
    chk("RST_DIGN", 32'(dig_n), 32'hF);
    drain("RST", 300);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
